// File: rtl/lane_deskew.sv
// lane_deskew: hunts a common alignment marker per lane, buffers each lane in a FIFO and
// releases word-aligned lane groups. Define LANE_DESKEW_RELOCK_CNT_EN to add relock_count.
module lane_deskew #(
  parameter int NUM_LANES = 4,
  parameter int LANE_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_SKEW = 6,
  parameter logic [LANE_WIDTH-1:0] ALIGN_MARKER = 32'hBC5A_A55A
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES-1:0]            in_valid,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_data,
  output logic [NUM_LANES-1:0]            lane_valid,
  output logic [NUM_LANES*LANE_WIDTH-1:0] lane_data,
  input  logic                            lane_ready,
  output logic                            locked,
  output logic                            deskew_err
`ifdef LANE_DESKEW_RELOCK_CNT_EN
  ,
  output logic [15:0]                     relock_count
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] SKEW_MAX = CNT_W'(MAX_SKEW);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  typedef enum logic [1:0] {HUNT = 2'd0, LOCKED = 2'd1, FLUSH = 2'd2} state_t;

  state_t               state_r, state_s;
  logic [NUM_LANES-1:0] marked_r, marked_s, push_s, hit_s, head_tag_s, nonempty_s, full_s;
  logic [CNT_W-1:0]     skew_cnt_r, skew_cur_s;
  logic [PTR_W-1:0]     wr_ptr_r [NUM_LANES];
  logic [PTR_W-1:0]     rd_ptr_r [NUM_LANES];
  logic [CNT_W-1:0]     cnt_r    [NUM_LANES];
  logic [LANE_WIDTH:0]  mem_r    [NUM_LANES][FIFO_DEPTH];
  logic                 pop_s, valid_s, misalign_s, overflow_s, flush_s, deskew_err_r;

  // Per-lane marker match and FIFO status decode
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      hit_s[i]      = (in_data[i*LANE_WIDTH +: LANE_WIDTH] == ALIGN_MARKER);
      nonempty_s[i] = (cnt_r[i] != {CNT_W{1'b0}});
      full_s[i]     = (cnt_r[i] == CNT_FULL);
      head_tag_s[i] = mem_r[i][rd_ptr_r[i]][LANE_WIDTH];
    end
  end

  // Next-state, push/pop and group release decisions
  always_comb begin
    state_s    = state_r;
    marked_s   = marked_r;
    push_s     = {NUM_LANES{1'b0}};
    pop_s      = 1'b0;
    valid_s    = 1'b0;
    misalign_s = 1'b0;
    overflow_s = 1'b0;
    // Counter reads as zero in the cycle that carries the first marker
    skew_cur_s = (|marked_r) ? skew_cnt_r : {CNT_W{1'b0}};
    case (state_r)
      HUNT: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (in_valid[i] && marked_r[i]) begin
            push_s[i] = 1'b1;
          end else if (in_valid[i] && hit_s[i]) begin
            marked_s[i] = 1'b1;
          end else begin
            push_s[i] = 1'b0;
          end
        end
        if (&marked_s) begin
          state_s = LOCKED;
        end else if ((|marked_s) && (skew_cur_s == SKEW_MAX)) begin
          state_s = FLUSH;
        end else begin
          state_s = HUNT;
        end
      end
      LOCKED: begin
        push_s = in_valid;
        if (&nonempty_s) begin
          if (&head_tag_s) begin
            pop_s = 1'b1;
          end else if (~|head_tag_s) begin
            valid_s = 1'b1;
            pop_s   = lane_ready;
          end else begin
            misalign_s = 1'b1;
          end
        end else begin
          pop_s = 1'b0;
        end
        overflow_s = (|(push_s & full_s)) && !pop_s;
        if (overflow_s || misalign_s) begin
          state_s = FLUSH;
        end else begin
          state_s = LOCKED;
        end
      end
      FLUSH:   state_s = HUNT;
      default: state_s = HUNT;
    endcase
  end

  assign flush_s = (state_r == FLUSH) || (state_s == FLUSH);

  // State, flags, skew counter and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= HUNT;
      marked_r     <= {NUM_LANES{1'b0}};
      skew_cnt_r   <= {CNT_W{1'b0}};
      deskew_err_r <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_ptr_r[i] <= {PTR_W{1'b0}};
        rd_ptr_r[i] <= {PTR_W{1'b0}};
        cnt_r[i]    <= {CNT_W{1'b0}};
      end
    end else begin
      state_r      <= state_s;
      deskew_err_r <= (state_s == FLUSH);
      if (flush_s) begin
        marked_r   <= {NUM_LANES{1'b0}};
        skew_cnt_r <= {CNT_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
          wr_ptr_r[i] <= {PTR_W{1'b0}};
          rd_ptr_r[i] <= {PTR_W{1'b0}};
          cnt_r[i]    <= {CNT_W{1'b0}};
        end
      end else begin
        marked_r <= marked_s;
        if ((state_r == HUNT) && (|marked_s) && !(&marked_s)) begin
          skew_cnt_r <= skew_cur_s + CNT_ONE;
        end else begin
          skew_cnt_r <= {CNT_W{1'b0}};
        end
        for (int i = 0; i < NUM_LANES; i++) begin
          if (push_s[i]) begin
            wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
          end
          if (pop_s) begin
            rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
          end
          cnt_r[i] <= cnt_r[i] + (push_s[i] ? CNT_ONE : {CNT_W{1'b0}})
                               - (pop_s ? CNT_ONE : {CNT_W{1'b0}});
        end
      end
    end
  end

  // FIFO storage: marker tag sits above the data word
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (push_s[i] && !flush_s) begin
        mem_r[i][wr_ptr_r[i]] <= {hit_s[i], in_data[i*LANE_WIDTH +: LANE_WIDTH]};
      end
    end
  end

  // Head words are shown only while a group is offered
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_data[i*LANE_WIDTH +: LANE_WIDTH] = valid_s ? mem_r[i][rd_ptr_r[i]][LANE_WIDTH-1:0]
                                                      : {LANE_WIDTH{1'b0}};
    end
  end

  assign lane_valid = {NUM_LANES{valid_s}};
  assign locked     = (state_r == LOCKED);
  assign deskew_err = deskew_err_r;

`ifdef LANE_DESKEW_RELOCK_CNT_EN
  logic        locked_once_r;
  logic [15:0] relock_cnt_r;

  // Count entries into LOCKED after the first, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_once_r <= 1'b0;
      relock_cnt_r  <= 16'h0000;
    end else if ((state_s == LOCKED) && (state_r != LOCKED)) begin
      locked_once_r <= 1'b1;
      if (locked_once_r && (relock_cnt_r != 16'hFFFF)) begin
        relock_cnt_r <= relock_cnt_r + 16'h0001;
      end
    end
  end

  assign relock_count = relock_cnt_r;
`endif
endmodule

// File: tb/tb_lane_deskew.sv
// Directed self-checking bench for lane_deskew: lock with skew, marker handling,
// skew limit, overflow, reset discard and (with LANE_DESKEW_RELOCK_CNT_EN) relock counting.
module tb_lane_deskew;
  localparam logic [31:0] MARK = 32'hBC5A_A55A;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   in_valid = 4'h0;
  logic [127:0] in_data = 128'h0;
  logic [3:0]   lane_valid;
  logic [127:0] lane_data;
  logic         lane_ready = 1'b0;
  logic         locked;
  logic         deskew_err;
`ifdef LANE_DESKEW_RELOCK_CNT_EN
  logic [15:0]  relock_count;
`endif

  int         checks = 0;
  int         failures = 0;
  int         m [4];
  logic [3:0] ext5 = 4'h0;
  logic [3:0] ext10 = 4'h0;

  lane_deskew dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .lane_valid (lane_valid),
    .lane_data  (lane_data),
    .lane_ready (lane_ready),
    .locked     (locked),
    .deskew_err (deskew_err)
`ifdef LANE_DESKEW_RELOCK_CNT_EN
    ,
    .relock_count (relock_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] grp(input int g);
    logic [31:0] w;
    w = 32'(g);
    return {w, w, w, w};
  endfunction

  // Lane i sends its marker at cycle m[i], then words 1, 2, ...; ext5/ext10 swap word 5/10 for a marker
  task automatic drive_k(input int k);
    int n;
    for (int i = 0; i < 4; i++) begin
      n = k - m[i];
      if (n == 0) in_data[i*32 +: 32] = MARK;
      else if (n < 0) in_data[i*32 +: 32] = 32'h0;
      else if ((n == 5 && ext5[i]) || (n == 10 && ext10[i])) in_data[i*32 +: 32] = MARK;
      else in_data[i*32 +: 32] = 32'(n);
    end
    in_valid = 4'hF;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_valid", 128'(lane_valid), 128'd0);
    chk("rst_data", lane_data, 128'd0);
    chk("rst_locked", 128'(locked), 128'd0);
    chk("rst_err", 128'(deskew_err), 128'd0);
`ifdef LANE_DESKEW_RELOCK_CNT_EN
    chk("rst_relock", 128'(relock_count), 128'd0);
`endif
    rst = 1'b0;

    // Skewed lock (0,2,1,3), aligned in-band markers at word 5, misaligned markers at word 10
    m = '{0, 2, 1, 3};
    ext5 = 4'hF;
    ext10 = 4'b0111;
    lane_ready = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      drive_k(k);
      tick();
      if (k < 3) begin
        chk("hunt_unlocked", 128'(locked), 128'd0);
      end else if (k == 3) begin
        chk("lock_edge", 128'(locked), 128'd1);
        chk("lock_no_group_yet", 128'(lane_valid), 128'd0);
      end else if (k == 8) begin
        chk("marker_group_valid", 128'(lane_valid), 128'd0);
        chk("marker_group_data", lane_data, 128'd0);
        chk("marker_no_err", 128'(deskew_err), 128'd0);
        chk("marker_still_locked", 128'(locked), 128'd1);
      end else if (k == 13) begin
        chk("misalign_no_group", 128'(lane_valid), 128'd0);
        chk("misalign_pre_locked", 128'(locked), 128'd1);
      end else if (k == 14) begin
        chk("misalign_err", 128'(deskew_err), 128'd1);
        chk("misalign_unlocked", 128'(locked), 128'd0);
        chk("misalign_valid", 128'(lane_valid), 128'd0);
      end else begin
        chk("group_valid", 128'(lane_valid), 128'hF);
        chk("group_data", lane_data, grp(k - 3));
        chk("group_no_err", 128'(deskew_err), 128'd0);
      end
    end
    in_valid = 4'h0;
    tick();
    chk("flush_err_clears", 128'(deskew_err), 128'd0);
    chk("flush_to_hunt", 128'(locked), 128'd0);

    // Skew of 7 cycles exceeds the limit
    m = '{0, 1, 1, 7};
    ext5 = 4'h0;
    ext10 = 4'h0;
    for (int k = 0; k <= 7; k++) begin
      drive_k(k);
      tick();
      chk("skew7_unlocked", 128'(locked), 128'd0);
      chk("skew7_err", 128'(deskew_err), (k == 6) ? 128'd1 : 128'd0);
    end
    in_valid = 4'h0;
    tick();
    chk("skew7_stays_unlocked", 128'(locked), 128'd0);

    // Skew of exactly 6 locks; then no ready and continuous input overflows lane 0
    m = '{0, 6, 3, 1};
    lane_ready = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      drive_k(k);
      tick();
      if (k < 6) begin
        chk("skew6_hunting", 128'(locked), 128'd0);
      end else if (k == 6) begin
        chk("skew6_locked", 128'(locked), 128'd1);
        chk("skew6_no_group", 128'(lane_valid), 128'd0);
      end else if (k < 9) begin
        chk("held_valid", 128'(lane_valid), 128'hF);
        chk("held_data", lane_data, grp(1));
        chk("held_no_err", 128'(deskew_err), 128'd0);
      end else begin
        chk("overflow_err", 128'(deskew_err), 128'd1);
        chk("overflow_unlocked", 128'(locked), 128'd0);
        chk("overflow_valid", 128'(lane_valid), 128'd0);
      end
    end
    in_valid = 4'h0;
    tick();
    chk("overflow_err_clears", 128'(deskew_err), 128'd0);
    chk("overflow_data_zero", lane_data, 128'd0);

    // Lock with zero skew, queue 5 words, then a one-cycle reset
    m = '{0, 0, 0, 0};
    for (int k = 0; k <= 5; k++) begin
      drive_k(k);
      tick();
      if (k == 0) chk("zero_skew_locked", 128'(locked), 128'd1);
      else chk("queued_head", lane_data, grp(1));
    end
    rst = 1'b1;
    drive_k(6);
    tick();
    chk("midrst_valid", 128'(lane_valid), 128'd0);
    chk("midrst_data", lane_data, 128'd0);
    chk("midrst_locked", 128'(locked), 128'd0);
    chk("midrst_err", 128'(deskew_err), 128'd0);
    rst = 1'b0;
    in_data = {MARK, MARK, MARK, MARK};
    tick();
    chk("relock_after_rst", 128'(locked), 128'd1);
    chk("stale_discarded", 128'(lane_valid), 128'd0);
    in_data = grp(7);
    tick();
    chk("fresh_group_valid", 128'(lane_valid), 128'hF);
    chk("fresh_group_data", lane_data, grp(7));

`ifdef LANE_DESKEW_RELOCK_CNT_EN
    // Three lock entries with misalignment errors in between
    rst = 1'b1;
    in_valid = 4'h0;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      in_data = {MARK, MARK, MARK, MARK};
      in_valid = 4'hF;
      tick();
      chk("round_locked", 128'(locked), 128'd1);
      chk("relock_count", 128'(relock_count), 128'(r));
      in_data = {32'h1, 32'h1, 32'h1, MARK};
      tick();
      in_valid = 4'h0;
      tick();
      chk("round_err", 128'(deskew_err), 128'd1);
      tick();
    end
    chk("relock_final", 128'(relock_count), 128'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
